// File: rtl/add_seq.sv
// add_seq: multi-cycle adder/subtractor that processes CHUNK bits per clock,
// LSB chunk first, holding the inter-chunk carry in a register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request, accepted only in IDLE or DONE
//   sub, cin          mode select (1 = num1 - num2) and add-mode carry-in
//   num1, num2        WIDTH-bit operands, latched on acceptance
//   busy              high while chunks are being processed
//   done              one-cycle pulse when out/cout/ovf are updated
//   out, cout, ovf    result, carry out of MSB, signed overflow
module add_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SAFE_CHUNK = (CHUNK == 0) ? 1 : CHUNK;
    localparam bit          PARAM_BAD  = (CHUNK == 0) || ((WIDTH % SAFE_CHUNK) != 0);
    localparam int unsigned N          = WIDTH / SAFE_CHUNK;
    localparam int unsigned CW         = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SW         = SAFE_CHUNK + 1;

    // Elaboration-time parameter sanity check
    if (PARAM_BAD) begin : g_param_err
        $error("add_seq: WIDTH must be a non-zero multiple of CHUNK (CHUNK >= 1)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IW-1:0]         base_c;
    logic [SAFE_CHUNK-1:0] a_chunk_c;
    logic [SAFE_CHUNK-1:0] b_chunk_c;
    logic [SW-1:0]         sum_c;
    logic                  msb_cin_c;

    // Chunk datapath, next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        base_c    = IW'(cnt_q * SAFE_CHUNK);
        a_chunk_c = a_q[base_c +: SAFE_CHUNK];
        b_chunk_c = b_q[base_c +: SAFE_CHUNK];
        sum_c     = {1'b0, a_chunk_c} + {1'b0, b_chunk_c} + SW'(carry_q);
        // Carry into the chunk MSB recovered from the MSB sum bit: s = a ^ b ^ c
        msb_cin_c = a_chunk_c[SAFE_CHUNK-1] ^ b_chunk_c[SAFE_CHUNK-1] ^ sum_c[SAFE_CHUNK-1];

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    // Subtract as num1 + ~num2 + 1
                    a_d     = num1;
                    b_d     = sub ? ~num2 : num2;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d[base_c +: SAFE_CHUNK] = sum_c[SAFE_CHUNK-1:0];
                carry_d = sum_c[SAFE_CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    out_d   = acc_d;
                    cout_d  = sum_c[SAFE_CHUNK];
                    ovf_d   = msb_cin_c ^ sum_c[SAFE_CHUNK];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: exercises a 16-bit/4-bit-chunk instance and a 4-bit single-chunk
// instance. Expected results are queued when an operation is launched and
// compared by per-instance monitors whenever done pulses.
module tb_add_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start16, sub16, cin16;
    logic [15:0] n1_16, n2_16, out16;
    logic        busy16, done16, cout16, ovf16;

    logic        start4, sub4, cin4;
    logic [3:0]  n1_4, n2_4, out4;
    logic        busy4, done4, cout4, ovf4;

    add_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
        .num1(n1_16), .num2(n2_16), .busy(busy16), .done(done16),
        .out(out16), .cout(cout16), .ovf(ovf16)
    );

    add_seq #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4),
        .num1(n1_4), .num2(n2_4), .busy(busy4), .done(done4),
        .out(out4), .cout(cout4), .ovf(ovf4)
    );

    typedef struct packed {
        logic [15:0] out;
        logic        cout;
        logic        ovf;
    } exp16_t;

    typedef struct packed {
        logic [3:0] out;
        logic       cout;
        logic       ovf;
    } exp4_t;

    typedef struct {
        logic [15:0] n1;
        logic [15:0] n2;
        logic        sub;
        logic        cin;
        logic [15:0] eout;
        logic        ecout;
        logic        eovf;
    } vec_t;

    exp16_t q16[$];
    exp4_t  q4[$];
    int     checks    = 0;
    int     failures  = 0;
    int     done16_cnt = 0;
    int     done4_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Full-width reference: two's-complement add, overflow from operand/result signs
    function automatic exp16_t model16(input logic [15:0] a, input logic [15:0] b,
                                       input logic s, input logic c);
        logic [15:0] bb;
        logic [16:0] f;
        exp16_t      e;
        bb     = s ? ~b : b;
        f      = {1'b0, a} + {1'b0, bb} + 17'(s ? 1'b1 : c);
        e.out  = f[15:0];
        e.cout = f[16];
        e.ovf  = (a[15] == bb[15]) && (f[15] != a[15]);
        return e;
    endfunction

    // Scoreboard monitor, 16-bit instance
    always @(posedge clk) begin : mon16
        exp16_t e;
        #1;
        if (done16) begin
            done16_cnt++;
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb16_unexpected_done: got done with out=0x%0h, expected no result", out16);
            end else begin
                e = q16.pop_front();
                chk("out16", 32'(out16), 32'(e.out));
                chk("cout16", 32'(cout16), 32'(e.cout));
                chk("ovf16", 32'(ovf16), 32'(e.ovf));
                chk("busy16_at_done", 32'(busy16), 32'd0);
            end
        end
    end

    // Scoreboard monitor, 4-bit instance
    always @(posedge clk) begin : mon4
        exp4_t e;
        #1;
        if (done4) begin
            done4_cnt++;
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb4_unexpected_done: got done with out=0x%0h, expected no result", out4);
            end else begin
                e = q4.pop_front();
                chk("out4", 32'(out4), 32'(e.out));
                chk("cout4", 32'(cout4), 32'(e.cout));
                chk("ovf4", 32'(ovf4), 32'(e.ovf));
            end
        end
    end

    // One 16-bit operation with latency/busy-width and post-done checks
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic c, input exp16_t e);
        int k;
        int nb;
        @(negedge clk);
        start16 = 1'b1; n1_16 = a; n2_16 = b; sub16 = s; cin16 = c;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
        nb = busy16 ? 1 : 0;
        k  = 0;
        while (!done16 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (busy16) nb++;
        end
        chk("latency16", 32'(k), 32'd4);
        chk("busy16_cycles", 32'(nb), 32'd4);
        @(posedge clk); #1;
        chk("done16_drop", 32'(done16), 32'd0);
        chk("out16_idle_hold", 32'(out16), 32'(e.out));
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] f;
        exp4_t      e;
        int         k;
        f      = {1'b0, a} + {1'b0, b};
        e.out  = f[3:0];
        e.cout = f[4];
        e.ovf  = (a[3] == b[3]) && (f[3] != a[3]);
        @(negedge clk);
        start4 = 1'b1; n1_4 = a; n2_4 = b; sub4 = 1'b0; cin4 = 1'b0;
        q4.push_back(e);
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("busy4_rise", 32'(busy4), 32'd1);
        k = 0;
        while (!done4 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency4", 32'(k), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "tb_add_seq timeout");
    end

    initial begin : main
        vec_t   vt[11];
        exp16_t e;
        logic [15:0] ra, rb;
        logic        rs, rc;
        int     k;
        int     d0;

        vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vt[3]  = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        vt[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vt[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vt[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0};

        rst = 1'b1;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; n1_16 = '0; n2_16 = '0;
        start4  = 1'b0; sub4  = 1'b0; cin4  = 1'b0; n1_4  = '0; n2_4  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_out", 32'(out16), 32'd0);
        chk("rst_cout", 32'(cout16), 32'd0);
        chk("rst_ovf", 32'(ovf16), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            e.out  = vt[i].eout;
            e.cout = vt[i].ecout;
            e.ovf  = vt[i].eovf;
            op16(vt[i].n1, vt[i].n2, vt[i].sub, vt[i].cin, e);
        end

        // Random operations against the full-width model
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            op16(ra, rb, rs, rc, model16(ra, rb, rs, rc));
        end

        // start held through RUN with changing operands: first operands only, one done
        d0 = done16_cnt;
        @(negedge clk);
        start16 = 1'b1; n1_16 = 16'h0100; n2_16 = 16'h0001; sub16 = 1'b0; cin16 = 1'b0;
        e.out = 16'h0101; e.cout = 1'b0; e.ovf = 1'b0;
        q16.push_back(e);
        repeat (3) begin
            @(negedge clk);
            n1_16 = 16'($urandom); n2_16 = 16'($urandom);
            sub16 = 1'($urandom);  cin16 = 1'($urandom);
        end
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("held_start_single_done", 32'(done16_cnt - d0), 32'd1);
        chk("held_start_idle", 32'(busy16), 32'd0);

        // Back-to-back: new start in the DONE cycle, previous result held until new done
        @(negedge clk);
        start16 = 1'b1; n1_16 = 16'h0003; n2_16 = 16'h0004; sub16 = 1'b0; cin16 = 1'b0;
        e.out = 16'h0007; e.cout = 1'b0; e.ovf = 1'b0;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
        k = 0;
        while (!done16 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b2b_first_latency", 32'(k), 32'd4);
        @(negedge clk);
        start16 = 1'b1; n1_16 = 16'h0010; n2_16 = 16'h0020;
        e.out = 16'h0030; e.cout = 1'b0; e.ovf = 1'b0;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("b2b_busy", 32'(busy16), 32'd1);
        chk("b2b_done_drop", 32'(done16), 32'd0);
        chk("b2b_out_held", 32'(out16), 32'h0007);
        k = 0;
        while (!done16 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (!done16) chk("b2b_out_held_run", 32'(out16), 32'h0007);
        end
        chk("b2b_second_latency", 32'(k), 32'd4);

        // Leave non-zero out/cout/ovf, then reset asynchronously mid-RUN
        e.out = 16'h0001; e.cout = 1'b1; e.ovf = 1'b1;
        op16(16'h8001, 16'h8000, 1'b0, 1'b0, e);
        @(negedge clk);
        start16 = 1'b1; n1_16 = 16'h1111; n2_16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0;
        @(posedge clk); #1;
        start16 = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy16), 32'd0);
        chk("arst_done", 32'(done16), 32'd0);
        chk("arst_out", 32'(out16), 32'd0);
        chk("arst_cout", 32'(cout16), 32'd0);
        chk("arst_ovf", 32'(ovf16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", 32'(busy16), 32'd0);
        chk("post_rst_idle_done", 32'(done16), 32'd0);
        e.out = 16'h3333; e.cout = 1'b0; e.ovf = 1'b0;
        op16(16'h1111, 16'h2222, 1'b0, 1'b0, e);

        // Exhaustive single-chunk add (N = 1), back-to-back from DONE
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b));
            end
        end
        repeat (3) @(posedge clk);
        #2;

        chk("sb16_drained", 32'(q16.size()), 32'd0);
        chk("sb4_drained", 32'(q4.size()), 32'd0);
        chk("done4_count", 32'(done4_cnt), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
Parametrised multi-cycle adder/subtractor, successor to the 4-bit combinational add block. Adds two WIDTH-bit operands CHUNK bits per clock, with carry held in a register between chunks, under a start/busy/done handshake. Used where a full-width single-cycle carry chain would limit Fmax. Also provides subtract mode, carry-in and signed-overflow flag.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0: num1+num2+cin; 1: num1-num2 (cin ignored)
cin  input  1  carry-in for add mode
num1  input  WIDTH  operand A, sampled with start
num2  input  WIDTH  operand B, sampled with start
busy  output  1  high while chunks are being processed
done  output  1  one-cycle pulse: result valid
out  output  WIDTH  result sum/difference
cout  output  1  carry out of MSB (sub mode: 1 = no borrow)
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- States: IDLE, RUN, DONE. Reset (async, any time incl. mid-operation): state=IDLE, busy=0, done=0, out=0, cout=0, ovf=0, chunk counter=0, carry register=0, operand latches=0.
- IDLE/DONE with start=1 at edge E0: latch num1, B = sub ? ~num2 : num2, carry = sub ? 1 : cin; counter=0; state→RUN; busy=1. Inputs other than clk/rst ignored afterwards until next acceptance.
- RUN, edges E1..EN: edge Ek adds chunk k-1 (bits [k*CHUNK-1:(k-1)*CHUNK], LSB chunk first) of A and B plus carry register; sum chunk written to internal accumulator, carry register updated; counter increments.
- At EN (counter reaches N-1 being processed): state→DONE, busy=0, done=1; out, cout, ovf loaded from accumulator/final carry/final carry-in to MSB. ovf computed from the MSB bit position of the last chunk.
- DONE: done high exactly one cycle. Next edge: start=1 → new operation (as from IDLE, done drops); start=0 → IDLE, done=0.
- Latency: done visible in the cycle after edge E(N); busy high exactly N cycles. WIDTH=CHUNK gives N=1.
- out/cout/ovf change only at completion edge; held stable through IDLE and through a following RUN until the next completion.
- start during RUN ignored (no queueing, no restart).
- Arithmetic modulo 2^WIDTH; {cout,out} equals the WIDTH+1-bit unsigned sum in add mode. Sub mode: out = (num1 - num2) mod 2^WIDTH, cout = (num1 >= num2 unsigned).
- Parameter check: elaboration error if WIDTH mod CHUNK != 0 or CHUNK < 1.

Test Plan:
- WIDTH=4, CHUNK=4, sub=0, cin=0, all 256 (num1,num2) pairs → {cout,out} == num1+num2, done one cycle after start edge, ovf correct per pair.
- WIDTH=16, CHUNK=4: num1=0xFFFF, num2=0x0001, cin=0 → busy 4 cycles, done pulse after edge E4, out=0x0000, cout=1, ovf=0; cin=1 with num2=0x0000 → same result.
- WIDTH=16, sub=1: 0x0005-0x0007 → out=0xFFFE, cout=0; 0x0007-0x0005 → out=0x0002, cout=1; 0x8000-0x0001 → out=0x7FFF, ovf=1.
- Signed overflow add: 0x7FFF+0x0001 → out=0x8000, cout=0, ovf=1; 0x8000+0x8000 → out=0x0000, cout=1, ovf=1.
- Handshake: start held high through RUN with changing operands → only first operands used, single done; start=1 in DONE cycle → back-to-back op, busy rises next cycle, previous out held until new done.
- Async reset asserted mid-RUN (between clock edges) → busy/done/out/cout/ovf 0 immediately; after release, IDLE, next start produces correct result.
